// File: rtl/pipe_sequencer.sv
// pipe_sequencer: run-control FSM plus load-use stall and branch-flush generation
// for the IF/ID and ID/EX pipeline registers.
module pipe_sequencer #(
    parameter int REG_AW       = 3,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              haltId,
    input  logic [REG_AW-1:0] idSrc1,
    input  logic [REG_AW-1:0] idSrc2,
    input  logic              idUse1,
    input  logic              idUse2,
    input  logic [REG_AW-1:0] exDst,
    input  logic              exRegWrite,
    input  logic              exMemRead,
    input  logic              branchTaken,
    output logic              pcEn,
    output logic              pcClear,
    output logic              ifIdEn,
    output logic              ifIdFlush,
    output logic              idExFlush,
    output logic              running,
    output logic              halted,
    output logic [CNT_W-1:0]  cycleCnt,
    output logic [CNT_W-1:0]  stallCnt
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, stall_q, stall_d;
    logic [CNT_W-1:0] cycle_inc, stall_inc;
    logic             hazard;

    assign hazard = exMemRead & exRegWrite &
                    ((idUse1 & (idSrc1 == exDst)) | (idUse2 & (idSrc2 == exDst)));
    assign cycle_inc = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
    assign stall_inc = (&stall_q) ? stall_q : stall_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        cycle_d   = cycle_q;
        stall_d   = stall_q;
        pcEn      = 1'b0;
        pcClear   = 1'b0;
        ifIdEn    = 1'b0;
        ifIdFlush = 1'b1;
        idExFlush = 1'b1;
        case (state_q)
            S_IDLE, S_HALTED: state_d = start ? S_LAUNCH : state_q;
            S_LAUNCH: begin
                pcClear = 1'b1;
                cycle_d = '0;
                stall_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cycle_d   = cycle_inc;
                pcEn      = 1'b1;
                ifIdEn    = 1'b1;
                ifIdFlush = 1'b0;
                idExFlush = 1'b0;
                // a taken branch squashes whatever sits in ID, hazard or halt
                if (branchTaken) begin
                    ifIdFlush = 1'b1;
                    idExFlush = 1'b1;
                end else if (hazard) begin
                    pcEn      = 1'b0;
                    ifIdEn    = 1'b0;
                    idExFlush = 1'b1;
                    stall_d   = stall_inc;
                end else if (haltId) begin
                    pcEn      = 1'b0;
                    ifIdFlush = 1'b1;
                    drain_d   = 4'(DRAIN_CYCLES);
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cycle_d   = cycle_inc;
                ifIdEn    = 1'b1;
                idExFlush = 1'b0;
                drain_d   = drain_q - 4'd1;
                state_d   = (drain_q == 4'd1) ? S_HALTED : S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            drain_q <= '0;
            cycle_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cycle_q <= cycle_d;
            stall_q <= stall_d;
        end
    end

    assign running  = (state_q == S_RUN) | (state_q == S_DRAIN);
    assign halted   = state_q == S_HALTED;
    assign cycleCnt = cycle_q;
    assign stallCnt = stall_q;
endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer: directed and random stimulus against a cycle-indexed
// reference model of the run-control and hazard rules.
module tb_pipe_sequencer;
    localparam int D = 3;
    localparam int M_IDLE = 0, M_LAUNCH = 1, M_RUN = 2, M_DRAIN = 3, M_HALTED = 4;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, haltId = 1'b0;
    logic [2:0] idSrc1 = '0, idSrc2 = '0, exDst = '0;
    logic idUse1 = 1'b0, idUse2 = 1'b0, exRegWrite = 1'b0, exMemRead = 1'b0, branchTaken = 1'b0;
    logic pcEn, pcClear, ifIdEn, ifIdFlush, idExFlush, running, halted;
    logic [15:0] cycleCnt, stallCnt;

    int errors = 0, checks = 0;
    int mode = M_IDLE, t = 0, halt_t = 0, cyc = 0, stl = 0;

    pipe_sequencer #(.REG_AW(3), .DRAIN_CYCLES(D), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .haltId(haltId),
        .idSrc1(idSrc1), .idSrc2(idSrc2), .idUse1(idUse1), .idUse2(idUse2),
        .exDst(exDst), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
        .branchTaken(branchTaken), .pcEn(pcEn), .pcClear(pcClear), .ifIdEn(ifIdEn),
        .ifIdFlush(ifIdFlush), .idExFlush(idExFlush), .running(running),
        .halted(halted), .cycleCnt(cycleCnt), .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic bit hz();
        return exMemRead && exRegWrite &&
               ((idUse1 && idSrc1 == exDst) || (idUse2 && idSrc2 == exDst));
    endfunction

    function automatic int sat(input int x);
        return x > 65535 ? 65535 : x;
    endfunction

    // {pcEn, ifIdEn, ifIdFlush, idExFlush}
    function automatic logic [3:0] exp_ctl();
        if (mode == M_RUN)
            return branchTaken ? 4'b1111 : hz() ? 4'b0001 : haltId ? 4'b0110 : 4'b1100;
        if (mode == M_DRAIN) return 4'b0110;
        return 4'b0011;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".ctl"}, 32'({pcEn, ifIdEn, ifIdFlush, idExFlush}), 32'(exp_ctl()));
        check({tag, ".pcClear"}, 32'(pcClear), 32'(mode == M_LAUNCH));
        check({tag, ".running"}, 32'(running), 32'(mode == M_RUN || mode == M_DRAIN));
        check({tag, ".halted"}, 32'(halted), 32'(mode == M_HALTED));
        check({tag, ".cycleCnt"}, 32'(cycleCnt), 32'(cyc));
        check({tag, ".stallCnt"}, 32'(stallCnt), 32'(stl));
    endtask

    task automatic model_reset();
        mode = M_IDLE;
        cyc = 0;
        stl = 0;
    endtask

    task automatic tick(input string tag);
        int nm, ncyc, nstl;
        #1;
        check_outputs(tag);
        nm = mode; ncyc = cyc; nstl = stl;
        case (mode)
            M_IDLE, M_HALTED: if (start) nm = M_LAUNCH;
            M_LAUNCH: begin nm = M_RUN; ncyc = 0; nstl = 0; end
            M_RUN: begin
                ncyc = sat(cyc + 1);
                if (!branchTaken && hz()) nstl = sat(stl + 1);
                else if (!branchTaken && haltId) begin nm = M_DRAIN; halt_t = t; end
            end
            M_DRAIN: begin
                ncyc = sat(cyc + 1);
                if (t - halt_t == D) nm = M_HALTED;
            end
            default: nm = M_IDLE;
        endcase
        @(posedge clk);
        mode = nm; cyc = ncyc; stl = nstl; t++;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {start, haltId, idUse1, idUse2, exRegWrite, exMemRead, branchTaken} = '0;
        idSrc1 = 3'd1; idSrc2 = 3'd2; exDst = 3'd3;
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        model_reset();
        #1 check_outputs(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        repeat (2) @(negedge clk);
        #1 check_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
        tick("idle");
        start = 1'b1; tick("start_req");
        start = 1'b0; tick("launch");
        repeat (3) tick("run");
        exMemRead = 1'b1; exRegWrite = 1'b1; exDst = 3'd5; idSrc2 = 3'd5; idUse2 = 1'b1;
        tick("stall");
        idUse2 = 1'b0; tick("nostall");
        idUse2 = 1'b1; haltId = 1'b1; branchTaken = 1'b1;
        tick("branch_wins");
        clear_inputs(); tick("post_branch");
        exMemRead = 1'b1; exRegWrite = 1'b1; exDst = 3'd0; idSrc1 = 3'd0; idUse1 = 1'b1; haltId = 1'b1;
        tick("r0_stall_beats_halt");
        clear_inputs(); haltId = 1'b1; tick("halt");
        haltId = 1'b0; start = 1'b1; branchTaken = 1'b1; tick("drain_start_ignored");
        start = 1'b0; branchTaken = 1'b0;
        repeat (4) tick("drain_to_halted");
        start = 1'b1; tick("restart");
        start = 1'b0; repeat (4) tick("run2");
        haltId = 1'b1; tick("halt2");
        haltId = 1'b0; tick("drain2");
        async_reset("async_rst_drain");
        tick("idle_after_rst");
        for (int i = 0; i < 3000; i++) begin
            start       = ($urandom_range(0, 3) == 0);
            haltId      = ($urandom_range(0, 15) == 0);
            branchTaken = ($urandom_range(0, 7) == 0);
            exMemRead   = ($urandom_range(0, 2) == 0);
            exRegWrite  = ($urandom_range(0, 3) != 0);
            idUse1      = $urandom_range(0, 1) == 1;
            idUse2      = $urandom_range(0, 1) == 1;
            idSrc1      = 3'($urandom_range(0, 7));
            idSrc2      = 3'($urandom_range(0, 7));
            exDst       = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) async_reset("rand_rst");
            else tick("rand");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
